// File: rtl/wiscsc15_pkg.sv
// ============================================================================
//  Module  : wiscsc15_pkg
//  Purpose : Shared opcodes, instruction classes, sequencer states and
//            datapath select encodings for the WISC-SC15 multi-cycle control.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package wiscsc15_pkg;

    localparam logic [3:0] OPC_ADD     = 4'h0;
    localparam logic [3:0] OPC_PADDSB  = 4'h1;
    localparam logic [3:0] OPC_SUB     = 4'h2;
    localparam logic [3:0] OPC_NAND    = 4'h3;
    localparam logic [3:0] OPC_XOR     = 4'h4;
    localparam logic [3:0] OPC_INC     = 4'h5;
    localparam logic [3:0] OPC_SRA     = 4'h6;
    localparam logic [3:0] OPC_SL      = 4'h7;
    localparam logic [3:0] OPC_LW      = 4'h8;
    localparam logic [3:0] OPC_SW      = 4'h9;
    localparam logic [3:0] OPC_LHB     = 4'hA;
    localparam logic [3:0] OPC_LLB     = 4'hB;
    localparam logic [3:0] OPC_B       = 4'hC;
    localparam logic [3:0] OPC_CALL    = 4'hD;
    localparam logic [3:0] OPC_RET     = 4'hE;
    localparam logic [3:0] OPC_ILLEGAL = 4'hF;

    typedef enum logic [3:0] {
        CLS_ARITH     = 4'd0,
        CLS_ARITH_IMM = 4'd1,
        CLS_LW        = 4'd2,
        CLS_SW        = 4'd3,
        CLS_LHB       = 4'd4,
        CLS_LLB       = 4'd5,
        CLS_B         = 4'd6,
        CLS_CALL      = 4'd7,
        CLS_RET       = 4'd8,
        CLS_ILLEGAL   = 4'd9
    } cls_t;

    typedef enum logic [2:0] {
        ST_HALT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
`ifdef WISC_CTRL_ILLEGAL_TRAP_EN
        , ST_TRAP = 3'd6
`endif
    } state_t;

    localparam logic       PC_SRC_NEXT   = 1'b0;
    localparam logic       PC_SRC_DM     = 1'b1;
    localparam logic       RF_WSRC_RD    = 1'b0;
    localparam logic       RF_WSRC_SP    = 1'b1;
    localparam logic [1:0] RF_RSRC1_RS   = 2'd0;
    localparam logic [1:0] RF_RSRC1_RD   = 2'd1;
    localparam logic [1:0] RF_RSRC1_SP   = 2'd2;
    localparam logic [1:0] RF_RSRC2_RT   = 2'd0;
    localparam logic [1:0] RF_RSRC2_RD   = 2'd1;
    localparam logic       ALU_SRC1_REG  = 1'b0;
    localparam logic       ALU_SRC1_ZERO = 1'b1;
    localparam logic [1:0] ALU_SRC2_REG  = 2'd0;
    localparam logic [1:0] ALU_SRC2_IMM  = 2'd1;
    localparam logic [1:0] ALU_SRC2_ONE  = 2'd2;
    localparam logic [1:0] ALU_SRC2_IMM8 = 2'd3;
    localparam logic       DM_IN_REG     = 1'b0;
    localparam logic       DM_IN_PC      = 1'b1;
    localparam logic       DM_ADDR_ALU   = 1'b0;
    localparam logic       DM_ADDR_SP    = 1'b1;
    localparam logic [1:0] RF_DATA_ALU   = 2'd0;
    localparam logic [1:0] RF_DATA_DM    = 2'd1;
    localparam logic [1:0] RF_DATA_LHB   = 2'd2;
    localparam logic [1:0] RF_DATA_LLB   = 2'd3;

    typedef struct packed {
        logic       pc_src;
        logic       rf_wsrc;
        logic [1:0] rf_rsrc1;
        logic [1:0] rf_rsrc2;
        logic       alu_src1;
        logic [1:0] alu_src2;
        logic       sel_call;
        logic       sel_branch;
        logic       dm_in;
        logic       dm_addr;
        logic [1:0] rf_data;
    } sel_t;

    localparam sel_t SEL_IDLE = '0;

    // Select set held for the whole path of one instruction class.
    function automatic sel_t class_sels(input cls_t cls);
        sel_t s;
        s = SEL_IDLE;
        case (cls)
            CLS_ARITH: begin
                s.alu_src2 = ALU_SRC2_REG;
            end
            CLS_ARITH_IMM: begin
                s.alu_src2 = ALU_SRC2_IMM;
            end
            CLS_LW: begin
                s.alu_src2 = ALU_SRC2_IMM;
                s.dm_addr  = DM_ADDR_ALU;
                s.rf_data  = RF_DATA_DM;
            end
            CLS_SW: begin
                s.alu_src2 = ALU_SRC2_IMM;
                s.rf_rsrc2 = RF_RSRC2_RD;
                s.dm_in    = DM_IN_REG;
            end
            CLS_LHB: begin
                s.rf_rsrc1 = RF_RSRC1_RD;
                s.alu_src2 = ALU_SRC2_IMM8;
                s.rf_data  = RF_DATA_LHB;
            end
            CLS_LLB: begin
                s.alu_src1 = ALU_SRC1_ZERO;
                s.alu_src2 = ALU_SRC2_IMM8;
                s.rf_data  = RF_DATA_LLB;
            end
            CLS_B: begin
                s.sel_branch = 1'b1;
            end
            CLS_CALL: begin
                s.sel_call = 1'b1;
                s.rf_rsrc1 = RF_RSRC1_SP;
                s.rf_wsrc  = RF_WSRC_SP;
                s.alu_src2 = ALU_SRC2_ONE;
                s.dm_addr  = DM_ADDR_SP;
                s.dm_in    = DM_IN_PC;
            end
            CLS_RET: begin
                s.pc_src   = PC_SRC_DM;
                s.rf_rsrc1 = RF_RSRC1_SP;
                s.rf_wsrc  = RF_WSRC_SP;
                s.alu_src2 = ALU_SRC2_ONE;
                s.dm_addr  = DM_ADDR_SP;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wiscsc15_opc_decode.sv
// ============================================================================
//  Module  : wiscsc15_opc_decode
//  Purpose : Combinational opcode to instruction-class and path-flag decode.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module wiscsc15_opc_decode
    import wiscsc15_pkg::*;
(
    input  logic [3:0] opcode,
    output cls_t       cls,
    output logic       needs_exec,
    output logic       needs_mem,
    output logic       mem_is_write,
    output logic       needs_wb
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_ADD, OPC_PADDSB, OPC_SUB, OPC_NAND, OPC_XOR: cls = CLS_ARITH;
            OPC_INC, OPC_SRA, OPC_SL:                        cls = CLS_ARITH_IMM;
            OPC_LW:                                          cls = CLS_LW;
            OPC_SW:                                          cls = CLS_SW;
            OPC_LHB:                                         cls = CLS_LHB;
            OPC_LLB:                                         cls = CLS_LLB;
            OPC_B:                                           cls = CLS_B;
            OPC_CALL:                                        cls = CLS_CALL;
            OPC_RET:                                         cls = CLS_RET;
            default:                                         cls = CLS_ILLEGAL;
        endcase
    end

    always_comb begin
        needs_exec   = 1'b1;
        needs_mem    = 1'b0;
        mem_is_write = 1'b0;
        needs_wb     = 1'b0;
        case (cls)
            CLS_ARITH, CLS_ARITH_IMM: needs_wb = 1'b1;
            CLS_LW: begin
                needs_mem = 1'b1;
                needs_wb  = 1'b1;
            end
            CLS_SW: begin
                needs_mem    = 1'b1;
                mem_is_write = 1'b1;
            end
            CLS_LHB, CLS_LLB: begin
                needs_exec = 1'b0;
                needs_wb   = 1'b1;
            end
            CLS_B: ;
            CLS_CALL: begin
                needs_mem    = 1'b1;
                mem_is_write = 1'b1;
                needs_wb     = 1'b1;
            end
            CLS_RET: begin
                needs_mem = 1'b1;
                needs_wb  = 1'b1;
            end
            default: needs_exec = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wiscsc15_mc_ctrl.sv
// ============================================================================
//  Module  : wiscsc15_mc_ctrl
//  Purpose : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with IM/DM
//            handshakes. Define WISC_CTRL_ILLEGAL_TRAP_EN to trap on 4'hF.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module wiscsc15_mc_ctrl
    import wiscsc15_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt_req,
    output logic               im_req,
    input  logic               im_ack,
    input  logic [3:0]         opcode,
    input  logic               cond_true,
    output logic               dm_req,
    input  logic               dm_ack,
    output logic               ir_we,
    output logic               pc_we,
    output logic               pc_src,
    output logic               rf_w,
    output logic               rf_wsrc,
    output logic [1:0]         rf_rsrc1,
    output logic [1:0]         rf_rsrc2,
    output logic               alu_src1,
    output logic [1:0]         alu_src2,
    output logic               sel_call,
    output logic               sel_branch,
    output logic               dm_in,
    output logic               dm_addr,
    output logic               dm_read,
    output logic               dm_write,
    output logic [1:0]         rf_data,
    output logic [ALUOP_W-1:0] aluop,
    output logic               busy,
    output logic               mem_err,
    output logic               trap
);

    state_t           r_state;
    logic [3:0]       r_opc;
    logic [TMO_W-1:0] r_cnt;
    logic             r_mem_err;

    cls_t w_cls;
    logic w_needs_exec;
    logic w_needs_mem;
    logic w_mem_is_write;
    logic w_needs_wb;
    logic w_ill;
    logic w_in_path;
    logic w_in_mem;
    logic w_mem_last;
    logic w_pc_we;
    sel_t w_sel;

    wiscsc15_opc_decode u_dec (
        .opcode       (r_opc),
        .cls          (w_cls),
        .needs_exec   (w_needs_exec),
        .needs_mem    (w_needs_mem),
        .mem_is_write (w_mem_is_write),
        .needs_wb     (w_needs_wb)
    );

    assign w_ill      = (w_cls == CLS_ILLEGAL);
    assign w_in_path  = r_state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB};
    assign w_in_mem   = (r_state == ST_MEM);
    assign w_mem_last = (r_cnt == TMO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_opc     <= '0;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (halt_req) begin
                        r_state <= ST_HALT;
                    end else if (im_ack) begin
                        r_opc   <= opcode;
                        r_state <= ST_DECODE;
                    end
                end
                ST_HALT: begin
                    if (!halt_req)
                        r_state <= ST_FETCH;
                end
                ST_DECODE: begin
                    if (w_ill)
`ifdef WISC_CTRL_ILLEGAL_TRAP_EN
                        r_state <= ST_TRAP;
`else
                        r_state <= ST_FETCH;
`endif
                    else if (w_needs_exec)
                        r_state <= ST_EXEC;
                    else if (w_needs_wb)
                        r_state <= ST_WB;
                    else
                        r_state <= ST_FETCH;
                end
                ST_EXEC: begin
                    if (w_needs_mem)
                        r_state <= ST_MEM;
                    else if (w_needs_wb)
                        r_state <= ST_WB;
                    else
                        r_state <= ST_FETCH;
                end
                ST_MEM: begin
                    // An ack on the final wait cycle still completes normally.
                    if (dm_ack) begin
                        r_cnt   <= '0;
                        r_state <= w_needs_wb ? ST_WB : ST_FETCH;
                    end else if (w_mem_last) begin
                        r_cnt     <= '0;
                        r_mem_err <= 1'b1;
                        r_state   <= ST_FETCH;
                    end else begin
                        r_cnt <= r_cnt + TMO_W'(1);
                    end
                end
                ST_WB: r_state <= ST_FETCH;
`ifdef WISC_CTRL_ILLEGAL_TRAP_EN
                ST_TRAP: r_state <= ST_TRAP;
`endif
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        w_pc_we = 1'b0;
        case (r_state)
`ifndef WISC_CTRL_ILLEGAL_TRAP_EN
            ST_DECODE: w_pc_we = w_ill;
`endif
            ST_EXEC:   w_pc_we = (w_cls == CLS_B) && cond_true;
            ST_MEM:    w_pc_we = dm_ack && !w_needs_wb;
            ST_WB:     w_pc_we = 1'b1;
            default:   w_pc_we = 1'b0;
        endcase
    end

    assign w_sel = w_in_path ? class_sels(w_cls) : SEL_IDLE;

    // im_req and busy are state-derived but must read 0 while rst is held.
    assign im_req     = !rst && (r_state == ST_FETCH) && !halt_req;
    assign ir_we      = im_req && im_ack;
    assign busy       = !rst && (r_state != ST_HALT);
    assign dm_req     = w_in_mem;
    assign dm_write   = w_in_mem && w_mem_is_write;
    assign dm_read    = w_in_mem && !w_mem_is_write;
    assign rf_w       = (r_state == ST_WB);
    assign pc_we      = w_pc_we;
    assign mem_err    = r_mem_err;
    assign aluop      = (w_in_path && !w_ill) ? ALUOP_W'(r_opc[2:0]) : '0;

    assign pc_src     = w_sel.pc_src;
    assign rf_wsrc    = w_sel.rf_wsrc;
    assign rf_rsrc1   = w_sel.rf_rsrc1;
    assign rf_rsrc2   = w_sel.rf_rsrc2;
    assign alu_src1   = w_sel.alu_src1;
    assign alu_src2   = w_sel.alu_src2;
    assign sel_call   = w_sel.sel_call;
    assign sel_branch = w_sel.sel_branch;
    assign dm_in      = w_sel.dm_in;
    assign dm_addr    = w_sel.dm_addr;
    assign rf_data    = w_sel.rf_data;

`ifdef WISC_CTRL_ILLEGAL_TRAP_EN
    assign trap = (r_state == ST_TRAP);
`else
    assign trap = 1'b0;
`endif

endmodule

`default_nettype wire
